event_generator_core: RTL and testbench
=======================================

EVENT_GENERATOR_CORE -- requirements
Module: event_generator_core

Interface
REQ-001 SHALL have parameter CNT_W, default 64, counter width in bits.
REQ-002 SHALL have parameter MISS_W, default 8, missed-event counter width in bits.
REQ-003 SHALL have port ck  input  1  single clock for all state; one clock, rising edge.
REQ-004 SHALL have port arstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port taskStart  input  1  one-cycle pulse: start counting.
REQ-006 SHALL have port taskStop  input  1  one-cycle pulse: stop counting.
REQ-007 SHALL have port taskClear  input  1  one-cycle pulse: zero count and prescaler.
REQ-008 SHALL have port cfgPrescaler  input  4  tick every 2^cfgPrescaler ck cycles.
REQ-009 SHALL have port cfgCompare  input  CNT_W  compare value.
REQ-010 SHALL have port cfgPeriodic  input  1  1 = count reloads to 0 on match.
REQ-011 SHALL have port count  output  CNT_W  current counter value.
REQ-012 SHALL have port running  output  1  1 while in RUNNING.
REQ-013 SHALL have port evtValid  output  1  event pending to consumer.
REQ-014 SHALL have port evtReady  input  1  consumer accepts event.
REQ-015 SHALL have port evtMissed  output  MISS_W  events lost while pending, saturating.

Function
REQ-016 SHALL implement FSM states STOPPED, RUNNING; taskStart in STOPPED -> RUNNING on next edge; taskStop -> STOPPED on next edge.
REQ-017 SHALL give taskStop priority when taskStart and taskStop assert in the same cycle; taskStart while RUNNING SHALL be ignored.
REQ-018 SHALL latch cfgPrescaler on the STOPPED->RUNNING transition; changes while RUNNING have no effect until next start.
REQ-019 SHALL generate tick while RUNNING when internal prescale counter == 2^latched-1, then wrap prescale counter to 0; prescaler 0 -> tick every cycle.
REQ-020 SHALL reset prescale counter to 0 on start and on taskClear.
REQ-021 SHALL, on tick with no match, set count <= count+1 modulo 2^CNT_W (all-ones wraps to 0, no event from wrap).
REQ-022 SHALL define match as tick && count == cfgCompare, cfgCompare sampled combinationally that cycle.
REQ-023 SHALL, on match, set count <= 0 if cfgPeriodic else count+1 (modulo), and raise event on the same edge.
REQ-024 SHALL give taskClear priority over tick: count <= 0, no match evaluated that cycle; taskClear works in either state, state unchanged.
REQ-025 SHALL hold evtValid until accepted (evtValid && evtReady); evtValid falls on the edge after acceptance.
REQ-026 SHALL keep evtValid 1 when a match coincides with acceptance (new event replaces accepted one, no miss).
REQ-027 SHALL increment evtMissed when a match occurs while evtValid=1 and evtReady=0; saturate at 2^MISS_W-1.
REQ-028 SHALL clear evtMissed only by reset; taskStop SHALL NOT clear evtValid or evtMissed.
REQ-029 SHALL drive running = (state == RUNNING), registered, no combinational input-to-output paths except none.

Reset
REQ-030 SHALL, on arstn low, asynchronously force state STOPPED, count 0, prescale counter 0, latched prescaler 0, evtValid 0, evtMissed 0, running 0.
REQ-031 SHALL, on reset mid-operation, discard pending event and count; first activity after release requires new taskStart.
REQ-032 SHALL ignore all task inputs while arstn is low.

Verification
REQ-033 Prescaler 0, compare 5, periodic 0, evtReady 1, taskStart -> count 1..6 consecutive cycles; evtValid 1 for exactly one cycle on edge where count goes 5->6.
REQ-034 Prescaler 2, compare 3, periodic 1, evtReady 1 -> count increments every 4 cycles, sequence 0,1,2,3,0,...; one event every 16 cycles.
REQ-035 Prescaler 0, compare 2, periodic 1, evtReady 0 for 20 cycles -> evtValid stays 1, evtMissed reaches 6; then evtReady 1 one cycle -> evtValid 0 next edge, evtMissed stays 6.
REQ-036 CNT_W=8, count 255, compare 7, tick -> count 0, no event; taskStart+taskStop same cycle -> running stays 0.
REQ-037 taskClear same cycle as matching tick (count == compare) -> count 0, no event, evtMissed unchanged.
REQ-038 arstn low mid-run with evtValid 1, evtMissed 3 -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/event_generator_core.sv
// Start/stop event generator: prescaled tick counter with compare match, optional
// periodic reload, and a valid/ready event output with a saturating missed-event count.
module event_generator_core #(
  parameter int CNT_W  = 64,
  parameter int MISS_W = 8
) (
  input  logic              ck,
  input  logic              arstn,
  input  logic              taskStart,
  input  logic              taskStop,
  input  logic              taskClear,
  input  logic [3:0]        cfgPrescaler,
  input  logic [CNT_W-1:0]  cfgCompare,
  input  logic              cfgPeriodic,
  output logic [CNT_W-1:0]  count,
  output logic              running,
  output logic              evtValid,
  input  logic              evtReady,
  output logic [MISS_W-1:0] evtMissed
);

  // Wide enough to hold 2^15-1, the terminal value for the largest prescaler.
  localparam int PS_W = 15;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } stateT;

  stateT           stateQ, stateD;
  logic            startEvt;
  logic [3:0]      psLatched;
  logic [PS_W-1:0] psCnt;
  logic [PS_W-1:0] psMask;
  logic            tick;
  logic            match;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    stateD   = stateQ;
    startEvt = 1'b0;
    case (stateQ)
      STOPPED: begin
        if (!taskStop && taskStart) begin
          stateD   = RUNNING;
          startEvt = 1'b1;
        end
      end
      RUNNING: begin
        if (taskStop) stateD = STOPPED;
      end
      default: stateD = STOPPED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge ck or negedge arstn) begin
    if (!arstn) stateQ <= STOPPED;
    else        stateQ <= stateD;
  end

  assign running = (stateQ == RUNNING);

  assign psMask = (PS_W'(1) << psLatched) - PS_W'(1);
  assign tick   = running && (psCnt == psMask);
  // A clear in the same cycle suppresses the compare entirely.
  assign match  = tick && !taskClear && (count == cfgCompare);

  always_ff @(posedge ck or negedge arstn) begin
    if (!arstn) begin
      psLatched <= '0;
      psCnt     <= '0;
    end else begin
      if (startEvt) psLatched <= cfgPrescaler;
      if (taskClear || startEvt) psCnt <= '0;
      else if (running)          psCnt <= tick ? '0 : psCnt + PS_W'(1);
    end
  end

  always_ff @(posedge ck or negedge arstn) begin
    if (!arstn) begin
      count <= '0;
    end else if (taskClear) begin
      count <= '0;
    end else if (tick) begin
      count <= (match && cfgPeriodic) ? '0 : count + CNT_W'(1);
    end
  end

  // A match on the accepting edge replaces the accepted event instead of dropping it.
  always_ff @(posedge ck or negedge arstn) begin
    if (!arstn) begin
      evtValid  <= 1'b0;
      evtMissed <= '0;
    end else begin
      if (match)                     evtValid <= 1'b1;
      else if (evtValid && evtReady) evtValid <= 1'b0;

      if (match && evtValid && !evtReady && (evtMissed != {MISS_W{1'b1}}))
        evtMissed <= evtMissed + MISS_W'(1);
    end
  end

endmodule

// File: tb/tb_event_generator_core.sv
// Bench for event_generator_core: a tick/event model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_event_generator_core;

  localparam int CNT_W  = 8;
  localparam int MISS_W = 4;

  logic              ck = 1'b0;
  logic              arstn = 1'b1;
  logic              taskStart = 1'b0;
  logic              taskStop = 1'b0;
  logic              taskClear = 1'b0;
  logic [3:0]        cfgPrescaler = '0;
  logic [CNT_W-1:0]  cfgCompare = '0;
  logic              cfgPeriodic = 1'b0;
  logic [CNT_W-1:0]  count;
  logic              running;
  logic              evtValid;
  logic              evtReady = 1'b0;
  logic [MISS_W-1:0] evtMissed;

  int checks = 0;
  int errors = 0;

  event_generator_core #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
    .ck(ck), .arstn(arstn),
    .taskStart(taskStart), .taskStop(taskStop), .taskClear(taskClear),
    .cfgPrescaler(cfgPrescaler), .cfgCompare(cfgCompare), .cfgPeriodic(cfgPeriodic),
    .count(count), .running(running),
    .evtValid(evtValid), .evtReady(evtReady), .evtMissed(evtMissed)
  );

  always #5 ck = ~ck;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a tick lands on every mDiv-th running cycle since start/clear.
  int mCount = 0, mElapsed = 0, mDiv = 1, mMissed = 0;
  bit mRun = 0, mValid = 0, mTick, mMatch;

  always @(posedge ck or negedge arstn) begin
    if (!arstn) begin
      mCount = 0; mElapsed = 0; mDiv = 1; mMissed = 0; mRun = 0; mValid = 0;
    end else begin
      mTick  = mRun && (((mElapsed + 1) % mDiv) == 0);
      mMatch = 0;
      if (taskClear) mCount = 0;
      else if (mTick) begin
        mMatch = (mCount == int'(cfgCompare));
        mCount = (mMatch && cfgPeriodic) ? 0 : (mCount + 1) % (1 << CNT_W);
      end
      if (mMatch && mValid && !evtReady && mMissed < (1 << MISS_W) - 1) mMissed++;
      if (mMatch) mValid = 1;
      else if (evtReady) mValid = 0;
      if (taskClear) mElapsed = 0;
      else if (mRun) mElapsed++;
      if (taskStop) mRun = 0;
      else if (taskStart && !mRun) begin
        mRun = 1; mDiv = 1 << cfgPrescaler; mElapsed = 0;
      end
    end
  end

  always @(negedge ck) begin
    check("model count", 64'(count), 64'(mCount));
    check("model running", 64'(running), 64'(mRun));
    check("model evtValid", 64'(evtValid), 64'(mValid));
    check("model evtMissed", 64'(evtMissed), 64'(mMissed));
  end

  task automatic pulseStart();
    taskStart = 1'b1; @(negedge ck); taskStart = 1'b0;
  endtask

  task automatic pulseStop();
    taskStop = 1'b1; @(negedge ck); taskStop = 1'b0;
  endtask

  task automatic pulseClear();
    taskClear = 1'b1; @(negedge ck); taskClear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int evCnt;
    bit found;

    #1 arstn = 1'b0;
    repeat (2) @(negedge ck);
    arstn = 1'b1;
    check("reset count", 64'(count), 64'd0);
    check("reset running", 64'(running), 64'd0);
    check("reset evtValid", 64'(evtValid), 64'd0);
    check("reset evtMissed", 64'(evtMissed), 64'd0);

    // Prescaler 0, compare 5, one-shot: count 1..7, event only on 5->6.
    cfgPrescaler = 4'd0; cfgCompare = 8'd5; cfgPeriodic = 1'b0; evtReady = 1'b1;
    pulseStart();
    check("start running", 64'(running), 64'd1);
    check("start count", 64'(count), 64'd0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge ck);
      check("p0 count", 64'(count), 64'(i));
      check("p0 evtValid", 64'(evtValid), 64'(i == 6));
    end
    pulseStop();
    check("stop running", 64'(running), 64'd0);
    @(negedge ck);
    check("stop holds count", 64'(count), 64'd8);

    // Prescaler 2, compare 3, periodic: one step per 4 cycles, event every 16.
    cfgPrescaler = 4'd2; cfgCompare = 8'd3; cfgPeriodic = 1'b1;
    pulseClear();
    check("clear count", 64'(count), 64'd0);
    pulseStart();
    cfgPrescaler = 4'd0;
    evCnt = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge ck);
      if (evtValid) evCnt++;
      if (i == 3) check("p2 no early tick", 64'(count), 64'd0);
      if (i == 4) check("p2 first tick", 64'(count), 64'd1);
    end
    check("p2 event count", 64'(evCnt), 64'd2);
    check("p2 reload", 64'(count), 64'd0);
    pulseStop();

    // Backpressure: events every 3 cycles with consumer stalled.
    cfgPrescaler = 4'd0; cfgCompare = 8'd2; cfgPeriodic = 1'b1; evtReady = 1'b0;
    pulseClear();
    pulseStart();
    repeat (21) @(negedge ck);
    check("stall evtMissed", 64'(evtMissed), 64'd6);
    check("stall evtValid", 64'(evtValid), 64'd1);
    pulseStop();
    check("stop keeps evtValid", 64'(evtValid), 64'd1);
    check("stop keeps evtMissed", 64'(evtMissed), 64'd6);
    evtReady = 1'b1; @(negedge ck); evtReady = 1'b0;
    check("accept evtValid", 64'(evtValid), 64'd0);
    check("accept evtMissed", 64'(evtMissed), 64'd6);

    // Match every tick: coincident accept keeps evtValid, then saturation.
    cfgCompare = 8'd0; evtReady = 1'b1;
    pulseClear();
    pulseStart();
    repeat (5) @(negedge ck);
    check("coincident evtValid", 64'(evtValid), 64'd1);
    check("coincident evtMissed", 64'(evtMissed), 64'd6);
    evtReady = 1'b0;
    repeat (12) @(negedge ck);
    check("saturated evtMissed", 64'(evtMissed), 64'd15);
    pulseStop();

    // Counter wrap at all-ones produces no event.
    evtReady = 1'b1; cfgCompare = 8'd7; cfgPeriodic = 1'b0;
    pulseClear();
    pulseStart();
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge ck);
      if (count == 8'hFF) found = 1;
    end
    check("reach 255", 64'(found), 64'd1);
    @(negedge ck);
    check("wrap count", 64'(count), 64'd0);
    check("wrap no event", 64'(evtValid), 64'd0);
    pulseStop();
    taskStart = 1'b1; taskStop = 1'b1;
    @(negedge ck);
    taskStart = 1'b0; taskStop = 1'b0;
    check("start+stop running", 64'(running), 64'd0);
    @(negedge ck);
    check("start+stop stays", 64'(running), 64'd0);

    // Clear coinciding with a matching tick.
    #2 arstn = 1'b0;
    @(negedge ck);
    arstn = 1'b1;
    cfgPrescaler = 4'd0; cfgCompare = 8'd3; cfgPeriodic = 1'b0; evtReady = 1'b0;
    pulseStart();
    repeat (4) @(negedge ck);
    check("pre-clear count", 64'(count), 64'd4);
    check("pre-clear evtValid", 64'(evtValid), 64'd1);
    cfgCompare = 8'd4;
    pulseClear();
    check("clear-match count", 64'(count), 64'd0);
    check("clear-match evtMissed", 64'(evtMissed), 64'd0);
    check("clear-match running", 64'(running), 64'd1);

    // Asynchronous reset mid-run with a pending event.
    cfgCompare = 8'd0; cfgPeriodic = 1'b1;
    repeat (3) @(negedge ck);
    check("pre-reset evtMissed", 64'(evtMissed), 64'd3);
    check("pre-reset evtValid", 64'(evtValid), 64'd1);
    #2 arstn = 1'b0;
    #1;
    check("async count", 64'(count), 64'd0);
    check("async running", 64'(running), 64'd0);
    check("async evtValid", 64'(evtValid), 64'd0);
    check("async evtMissed", 64'(evtMissed), 64'd0);
    taskStart = 1'b1;
    repeat (2) @(negedge ck);
    taskStart = 1'b0;
    arstn = 1'b1;
    check("start in reset ignored", 64'(running), 64'd0);
    repeat (3) @(negedge ck);
    check("post-reset running", 64'(running), 64'd0);
    check("post-reset count", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
